vic_irq_arbiter: RTL and testbench

- Prioritising interrupt scheduler between the external interrupt lines and the VIC control unit.
- Detects edges on 31 external lines, keeps pending state, applies per-line enables and fixed priority, and presents one request (id + ISR address) to the control unit with a req/ack handshake.
- Tracks nested in-service interrupts on a small stack popped by `i_reti`, so only strictly higher-priority lines preempt the running ISR.

---
 rtl/vic_pkg.sv | 25 ++
 rtl/vic_prio_enc.sv | 30 +++
 rtl/vic_irq_arbiter.sv | 150 +++++++++++++++
 tb/tb_vic_irq_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vic_pkg
// Description : Shared constants and FSM state encoding for the VIC
//               interrupt arbiter and its priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package vic_pkg;

  localparam int NUM_IRQ    = 31;  // external lines, id 0 = highest priority
  localparam int ID_W       = 5;   // interrupt id width
  localparam int NEST_DEPTH = 4;   // max simultaneously in-service ISRs
  localparam int DEPTH_W    = 3;   // holds 0..NEST_DEPTH
  localparam int SP_W       = $clog2(NEST_DEPTH);

  // Reported as the current id when nothing is in service; it is above
  // every real id, so any candidate preempts an empty stack.
  localparam logic [ID_W-1:0] NO_IRQ_ID = 5'd31;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_REQ  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/vic_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : vic_prio_enc
// Description : Fixed-priority encoder; returns the index of the lowest set
//               bit of req and a valid flag.
// Ports       : req   - request vector
//               valid - at least one bit of req is set
//               id    - index of the lowest set bit (0 when none)
// Revision    : 1.0 - initial release
// ============================================================================
module vic_prio_enc #(
  parameter int WIDTH    = 31,
  parameter int ID_WIDTH = 5
) (
  input  logic [WIDTH-1:0]    req,
  output logic                valid,
  output logic [ID_WIDTH-1:0] id
);

  // Scan from the top down so the lowest set index is the last to write.
  always_comb begin
    valid = |req;
    id    = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) id = ID_WIDTH'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/vic_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vic_irq_arbiter
// Description : Edge-detecting, fixed-priority interrupt scheduler with a
//               nesting stack and req/ack handshake to the VIC control unit.
// Ports       : clk, rst (async, active low)
//               i_ext, i_enable, i_pend_clr  - lines, enables, pending clear
//               i_vec_base                   - vector table base
//               o_irq_req/o_irq_id/o_isr_addr, i_irq_ack - request handshake
//               i_reti, o_reti_err           - ISR return / return underflow
//               o_pending, o_depth, o_cur_id - status
// Revision    : 1.0 - initial release
// ============================================================================
module vic_irq_arbiter
  import vic_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] i_ext,
  input  logic [NUM_IRQ-1:0] i_enable,
  input  logic [NUM_IRQ-1:0] i_pend_clr,
  input  logic [31:0]        i_vec_base,
  output logic               o_irq_req,
  output logic [ID_W-1:0]    o_irq_id,
  output logic [31:0]        o_isr_addr,
  input  logic               i_irq_ack,
  input  logic               i_reti,
  output logic [NUM_IRQ-1:0] o_pending,
  output logic [DEPTH_W-1:0] o_depth,
  output logic [ID_W-1:0]    o_cur_id,
  output logic               o_reti_err
);

  logic [NUM_IRQ-1:0] r_sync1, r_sync2, r_prev, r_pending;
  logic [NUM_IRQ-1:0] w_edge, w_masked, w_ack_mask;
  state_t             r_state;
  logic               r_irq_req, r_reti_err;
  logic [ID_W-1:0]    r_irq_id;
  logic [ID_W-1:0]    r_stack [NEST_DEPTH];
  logic [DEPTH_W-1:0] r_depth;

  logic               w_cand_valid, w_eligible, w_ack_fire, w_empty, w_pop;
  logic [ID_W-1:0]    w_cand_id, w_cur_id;
  logic [SP_W-1:0]    w_top_idx, w_push_idx;
  logic               w_unused_base;

  assign w_unused_base = ^i_vec_base[1:0];

  // ---------------- synchroniser + rising-edge detect ----------------
  assign w_edge = r_sync2 & ~r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= i_ext;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // ---------------- pending register ----------------
  assign w_ack_fire = (r_state == ST_REQ) && i_irq_ack;
  assign w_ack_mask = w_ack_fire ? (NUM_IRQ'(1) << r_irq_id) : '0;

  // A new edge wins over a same-cycle software clear or ack clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pending <= '0;
    else      r_pending <= w_edge | (r_pending & ~(i_pend_clr | w_ack_mask));
  end

  // ---------------- candidate selection ----------------
  assign w_masked = r_pending & i_enable;

  vic_prio_enc #(
    .WIDTH    (NUM_IRQ),
    .ID_WIDTH (ID_W)
  ) u_prio_enc (
    .req   (w_masked),
    .valid (w_cand_valid),
    .id    (w_cand_id)
  );

  assign w_eligible = w_cand_valid && (w_cand_id < w_cur_id) &&
                      (r_depth < DEPTH_W'(NEST_DEPTH));

  // ---------------- in-service stack ----------------
  assign w_empty   = (r_depth == '0);
  assign w_pop     = i_reti && !w_empty;
  assign w_top_idx = SP_W'(r_depth - DEPTH_W'(1));
  // Pop-then-push in one cycle overwrites the current top in place.
  assign w_push_idx = w_pop ? w_top_idx : r_depth[SP_W-1:0];
  assign w_cur_id   = w_empty ? NO_IRQ_ID : r_stack[w_top_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NEST_DEPTH; i++) r_stack[i] <= '0;
      r_depth    <= '0;
      r_reti_err <= 1'b0;
    end else begin
      r_reti_err <= i_reti && w_empty;
      if (w_ack_fire) r_stack[w_push_idx] <= r_irq_id;
      case ({w_ack_fire, w_pop})
        2'b10:   r_depth <= r_depth + DEPTH_W'(1);
        2'b01:   r_depth <= r_depth - DEPTH_W'(1);
        default: r_depth <= r_depth;
      endcase
    end
  end

  // ---------------- request FSM ----------------
  // Once in REQ the id is frozen until ack; nothing withdraws the request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_irq_req <= 1'b0;
      r_irq_id  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_eligible) begin
            r_irq_req <= 1'b1;
            r_irq_id  <= w_cand_id;
            r_state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (i_irq_ack) begin
            r_irq_req <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_irq_req  = r_irq_req;
  assign o_irq_id   = r_irq_id;
  assign o_isr_addr = {i_vec_base[31:2], 2'b00} +
                      {{(30-ID_W){1'b0}}, r_irq_id, 2'b00};
  assign o_pending  = r_pending;
  assign o_depth    = r_depth;
  assign o_cur_id   = w_cur_id;
  assign o_reti_err = r_reti_err;

endmodule
`default_nettype wire

// File: tb/tb_vic_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vic_irq_arbiter
// Description : Self-checking bench for vic_irq_arbiter; expected requests
//               are queued when lines are raised and popped on each request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vic_irq_arbiter;

  logic        clk, rst;
  logic [30:0] i_ext, i_enable, i_pend_clr;
  logic [31:0] i_vec_base;
  logic        o_irq_req, i_irq_ack, i_reti, o_reti_err;
  logic [4:0]  o_irq_id, o_cur_id;
  logic [31:0] o_isr_addr;
  logic [30:0] o_pending;
  logic [2:0]  o_depth;

  int n_checks = 0;
  int n_errs   = 0;
  int exp_q[$];
  int mstk[$];
  int last_id  = 0;

  vic_irq_arbiter u_dut (
    .clk        (clk),
    .rst        (rst),
    .i_ext      (i_ext),
    .i_enable   (i_enable),
    .i_pend_clr (i_pend_clr),
    .i_vec_base (i_vec_base),
    .o_irq_req  (o_irq_req),
    .o_irq_id   (o_irq_id),
    .o_isr_addr (o_isr_addr),
    .i_irq_ack  (i_irq_ack),
    .i_reti     (i_reti),
    .o_pending  (o_pending),
    .o_depth    (o_depth),
    .o_cur_id   (o_cur_id),
    .o_reti_err (o_reti_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ext(input int id);
    i_ext[id] = 1'b1;
    step();
    i_ext[id] = 1'b0;
  endtask

  task automatic chk_stack(input string tag);
    check_val({tag, "_depth"}, 32'(o_depth), 32'(mstk.size()));
    check_val({tag, "_cur"}, 32'(o_cur_id), (mstk.size() > 0) ? 32'(mstk[$]) : 32'd31);
  endtask

  task automatic wait_req(input string tag);
    int n;
    int eid;
    n = 0;
    while (!o_irq_req && n < 20) begin
      step();
      n++;
    end
    if (!o_irq_req) check_val({tag, "_timeout"}, 32'(o_irq_req), 32'd1);
    else if (exp_q.size() == 0) check_val({tag, "_unexpected"}, 32'(o_irq_id), 32'hFFFF_FFFF);
    else begin
      eid     = exp_q.pop_front();
      last_id = eid;
      check_val({tag, "_id"}, 32'(o_irq_id), 32'(eid));
      check_val({tag, "_addr"}, o_isr_addr, 32'h1000 + 32'(eid) * 4);
    end
  endtask

  task automatic do_ack(input string tag);
    i_irq_ack = 1'b1;
    step();
    i_irq_ack = 1'b0;
    mstk.push_back(last_id);
    check_val({tag, "_req_drop"}, 32'(o_irq_req), 32'd0);
    check_val({tag, "_pend_clr"}, 32'(o_pending[last_id]), 32'd0);
    chk_stack(tag);
  endtask

  task automatic do_reti(input string tag);
    i_reti = 1'b1;
    step();
    i_reti = 1'b0;
    if (mstk.size() > 0) void'(mstk.pop_back());
    chk_stack(tag);
  endtask

  task automatic idle_for(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      step();
      if (o_irq_req) seen = 1;
    end
    check_val(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int bad;
    rst = 1'b0; i_ext = '0; i_enable = '1; i_pend_clr = '0;
    i_vec_base = 32'h0000_1003; i_irq_ack = 1'b0; i_reti = 1'b0;
    #3;
    check_val("rst_req", 32'(o_irq_req), 0);
    check_val("rst_id", 32'(o_irq_id), 0);
    check_val("rst_addr", o_isr_addr, 32'h1000);
    check_val("rst_depth", 32'(o_depth), 0);
    check_val("rst_cur", 32'(o_cur_id), 31);
    check_val("rst_pend", 32'(o_pending), 0);
    check_val("rst_err", 32'(o_reti_err), 0);
    repeat (3) step();
    rst = 1'b1;
    step();

    // Single edge with exact latency
    exp_q.push_back(5);
    i_ext[5] = 1'b1;
    step();
    i_ext[5] = 1'b0;
    step();
    check_val("lat_k1_req", 32'(o_irq_req), 0);
    step();
    check_val("lat_k2_pend", 32'(o_pending[5]), 1);
    check_val("lat_k2_req", 32'(o_irq_req), 0);
    step();
    check_val("lat_k3_req", 32'(o_irq_req), 1);
    wait_req("single");
    do_ack("single_ack");
    do_reti("single_reti");

    // Priority between simultaneous edges
    exp_q.push_back(3);
    i_ext[9] = 1'b1; i_ext[3] = 1'b1;
    step();
    i_ext[9] = 1'b0; i_ext[3] = 1'b0;
    wait_req("prio3");
    do_ack("prio3_ack");
    idle_for("prio9_blocked", 8);
    exp_q.push_back(9);
    do_reti("prio3_reti");
    wait_req("prio9");
    do_ack("prio9_ack");

    // Preemption by higher priority
    exp_q.push_back(2);
    pulse_ext(2);
    wait_req("preempt2");
    do_ack("preempt2_ack");
    do_reti("preempt_reti1");
    do_reti("preempt_reti2");

    // Request stays stable through higher arrival, disable and clear
    exp_q.push_back(7);
    pulse_ext(7);
    wait_req("stable7");
    exp_q.push_back(1);
    pulse_ext(1);
    i_enable[7] = 1'b0;
    i_pend_clr[7] = 1'b1;
    step();
    i_pend_clr[7] = 1'b0;
    bad = 0;
    repeat (5) begin
      step();
      if (!o_irq_req || o_irq_id !== 5'd7) bad = 1;
    end
    i_enable[7] = 1'b1;
    check_val("stable7_hold", 32'(bad), 0);
    do_ack("stable7_ack");
    wait_req("after7");
    do_ack("after7_ack");
    do_reti("stable_reti1");
    do_reti("stable_reti2");

    // Stack full
    foreach (mstk[i]) ;
    begin
      int ids[4] = '{20, 15, 10, 5};
      foreach (ids[i]) begin
        exp_q.push_back(ids[i]);
        pulse_ext(ids[i]);
        wait_req("full_fill");
        do_ack("full_fill_ack");
      end
    end
    pulse_ext(0);
    idle_for("full_blocked", 8);
    check_val("full_pend0", 32'(o_pending[0]), 1);
    exp_q.push_back(0);
    do_reti("full_reti");
    wait_req("full_req0");
    do_ack("full_ack0");
    repeat (4) do_reti("full_drain");

    // Return on empty stack
    i_reti = 1'b1;
    step();
    i_reti = 1'b0;
    check_val("reti_err_pulse", 32'(o_reti_err), 1);
    check_val("reti_err_depth", 32'(o_depth), 0);
    step();
    check_val("reti_err_once", 32'(o_reti_err), 0);

    // Return and ack in the same cycle
    exp_q.push_back(12);
    pulse_ext(12);
    wait_req("swap12");
    do_ack("swap12_ack");
    exp_q.push_back(4);
    pulse_ext(4);
    wait_req("swap4");
    i_reti = 1'b1; i_irq_ack = 1'b1;
    step();
    i_reti = 1'b0; i_irq_ack = 1'b0;
    void'(mstk.pop_back());
    mstk.push_back(last_id);
    chk_stack("swap");
    do_reti("swap_reti");

    // Edge and software clear on the same bit
    i_enable[6] = 1'b0;
    i_ext[6] = 1'b1;
    step();
    i_ext[6] = 1'b0;
    step();
    i_pend_clr[6] = 1'b1;
    step();
    i_pend_clr[6] = 1'b0;
    check_val("set_wins", 32'(o_pending[6]), 1);
    i_pend_clr[6] = 1'b1;
    step();
    i_pend_clr[6] = 1'b0;
    check_val("pend_clr", 32'(o_pending[6]), 0);

    // Disabled line latches pending, request follows enable
    pulse_ext(6);
    idle_for("disabled_noreq", 6);
    check_val("disabled_pend", 32'(o_pending[6]), 1);
    exp_q.push_back(6);
    i_enable[6] = 1'b1;
    step();
    check_val("enable_req", 32'(o_irq_req), 1);
    wait_req("enable6");
    do_ack("enable6_ack");
    do_reti("enable6_reti");

    // Asynchronous reset mid-handshake with depth 2
    exp_q.push_back(25);
    pulse_ext(25);
    wait_req("rst25");
    do_ack("rst25_ack");
    exp_q.push_back(22);
    pulse_ext(22);
    wait_req("rst22");
    do_ack("rst22_ack");
    exp_q.push_back(11);
    pulse_ext(11);
    wait_req("rst11");
    rst = 1'b0;
    #1;
    check_val("arst_req", 32'(o_irq_req), 0);
    check_val("arst_id", 32'(o_irq_id), 0);
    check_val("arst_depth", 32'(o_depth), 0);
    check_val("arst_cur", 32'(o_cur_id), 31);
    check_val("arst_pend", 32'(o_pending), 0);
    check_val("arst_addr", o_isr_addr, 32'h1000);
    mstk.delete();
    step();
    step();
    rst = 1'b1;
    idle_for("post_rst_noreq", 8);
    exp_q.push_back(8);
    pulse_ext(8);
    wait_req("post_rst8");
    do_ack("post_rst8_ack");
    do_reti("post_rst_reti");
    check_val("queue_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
